// File: rtl/sram_pkg.sv
// sram_pkg: shared constants and types for the banked two-port SRAM controller.
//   MACRO_WORDS/MACRO_W/MACRO_AW : geometry of one sram_32b_w2048 macro
//   port_id_t                    : names one of the two request ports
package sram_pkg;
  localparam int MACRO_WORDS = 2048;
  localparam int MACRO_W     = 32;
  localparam int MACRO_AW    = 11;

  typedef logic port_id_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/sram_banked_2p_if.sv
// sram_banked_2p_if: one valid/ready request port plus its read response.
//   valid/we/addr/wdata : request (master -> slave)
//   ready               : request accepted this cycle when valid&ready
//   rvalid/rdata        : read response, one cycle after acceptance
interface sram_banked_2p_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/sram_32b_w2048.sv
// sram_32b_w2048: behavioural model of the 2048x32 single-port macro.
//   CLK, CEN (active low), WEN (active low), A[10:0], D[31:0], Q[31:0]
//   One-cycle read latency; Q holds between reads.
module sram_32b_w2048 (
  input  logic        CLK,
  input  logic        CEN,
  input  logic        WEN,
  input  logic [10:0] A,
  input  logic [31:0] D,
  output logic [31:0] Q
);
  logic [31:0] mem [0:2047];

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else      Q      <= mem[A];
    end
  end
endmodule

// File: rtl/sram_bank_slice.sv
// sram_bank_slice: one depth bank, DATA_W/32 macros side by side sharing
// control and address.
//   CLK, CEN, WEN, A[10:0], D[DATA_W-1:0], Q[DATA_W-1:0]
module sram_bank_slice import sram_pkg::*; #(
  parameter int DATA_W = 64
) (
  input  logic                CLK,
  input  logic                CEN,
  input  logic                WEN,
  input  logic [MACRO_AW-1:0] A,
  input  logic [DATA_W-1:0]   D,
  output logic [DATA_W-1:0]   Q
);
  localparam int SLICES = DATA_W / MACRO_W;

  for (genvar s = 0; s < SLICES; s++) begin : g_mac
    sram_32b_w2048 u_mac (
      .CLK (CLK),
      .CEN (CEN),
      .WEN (WEN),
      .A   (A),
      .D   (D[s*MACRO_W +: MACRO_W]),
      .Q   (Q[s*MACRO_W +: MACRO_W])
    );
  end
endmodule

// File: rtl/sram_banked_2p.sv
// sram_banked_2p: two-port banked SRAM controller.
//   CLK, RESET (sync, active high)
//   p0, p1    : request/response ports (sram_banked_2p_if.slave)
//   stall_cnt : saturating count of cycles with a bank-conflict refusal
// Ports hitting different banks proceed together; a same-bank collision
// refuses one port. Fixed priority (port 0) by default; define
// SRAM_RR_ARB_EN for round-robin on conflicts.
module sram_banked_2p import sram_pkg::*; #(
  parameter  int NUM_WORDS = 4096,
  parameter  int DATA_W    = 64,
  localparam int ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic               CLK,
  input  logic               RESET,
  sram_banked_2p_if.slave    p0,
  sram_banked_2p_if.slave    p1,
  output logic [15:0]        stall_cnt
);
  localparam int NB     = ceil_div(NUM_WORDS, MACRO_WORDS);
  localparam int BANK_W = (ADDR_W > MACRO_AW) ? ADDR_W - MACRO_AW : 1;
  localparam logic [BANK_W:0] NB_V = (BANK_W+1)'(NB);

  logic [1:0]                   v, we, rdy, acc, oor;
  logic [1:0][ADDR_W-1:0]       a;
  logic [1:0][DATA_W-1:0]       wd, rd;
  logic [1:0][BANK_W-1:0]       bank;
  logic [1:0][MACRO_AW-1:0]     maddr;

  assign v  = {p1.valid, p0.valid};
  assign we = {p1.we,    p0.we};
  assign a  = {p1.addr,  p0.addr};
  assign wd = {p1.wdata, p0.wdata};

  for (genvar p = 0; p < 2; p++) begin : g_dec
    if (ADDR_W > MACRO_AW) begin : g_multi
      assign bank[p]  = a[p][ADDR_W-1:MACRO_AW];
      assign maddr[p] = a[p][MACRO_AW-1:0];
    end else begin : g_single
      assign bank[p]  = '0;
      assign maddr[p] = MACRO_AW'(a[p]);
    end
    // Out-of-range banks have no macro behind them: never conflict.
    assign oor[p] = ({1'b0, bank[p]} >= NB_V);
  end

  logic     conflict;
  port_id_t win;

  assign conflict = &v & ~|oor & (bank[0] == bank[1]);

`ifdef SRAM_RR_ARB_EN
  port_id_t rr_ptr;
  assign win = rr_ptr;
  always_ff @(posedge CLK) begin
    if (RESET)         rr_ptr <= 1'b0;
    else if (conflict) rr_ptr <= ~win;  // prefer the loser next time
  end
`else
  assign win = 1'b0;
`endif

  assign rdy[0] = ~RESET & ~(conflict &  win);
  assign rdy[1] = ~RESET & ~(conflict & ~win);
  assign acc    = v & rdy;

  // Bank drive: at most one port can select a given bank after arbitration.
  logic [NB-1:0][DATA_W-1:0] q;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic sel0, sel1;
    assign sel0 = acc[0] & ~oor[0] & (bank[0] == BANK_W'(b));
    assign sel1 = acc[1] & ~oor[1] & (bank[1] == BANK_W'(b));

    sram_bank_slice #(.DATA_W(DATA_W)) u_bank (
      .CLK (CLK),
      .CEN (~(sel0 | sel1)),
      .WEN (sel1 ? ~we[1] : ~we[0]),
      .A   (sel1 ? maddr[1] : maddr[0]),
      .D   (sel1 ? wd[1] : wd[0]),
      .Q   (q[b])
    );
  end

  // Read tracking: bank captured at acceptance steers the response mux.
  logic [1:0]              rvld, roor;
  logic [1:0][BANK_W-1:0]  rbank;
  logic [1:0][DATA_W-1:0]  rhold;

  always_ff @(posedge CLK) begin
    for (int p = 0; p < 2; p++) begin
      // acc is already forced low under RESET, so a read accepted the
      // cycle before reset still gets its response during reset.
      rvld[p] <= acc[p] & ~we[p];
      if (acc[p]) begin
        rbank[p] <= bank[p];
        roor[p]  <= oor[p];
      end
      if (RESET)        rhold[p] <= '0;
      else if (rvld[p]) rhold[p] <= rd[p];
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = rhold[p];
      if (rvld[p]) begin
        rd[p] = '0;
        if (!roor[p])
          for (int b = 0; b < NB; b++)
            if (rbank[p] == BANK_W'(b)) rd[p] = q[b];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)                             stall_cnt <= '0;
    else if (conflict && stall_cnt != '1)  stall_cnt <= stall_cnt + 16'd1;
  end

  assign p0.ready  = rdy[0];
  assign p1.ready  = rdy[1];
  assign p0.rvalid = rvld[0];
  assign p1.rvalid = rvld[1];
  assign p0.rdata  = rd[0];
  assign p1.rdata  = rd[1];
endmodule

// File: tb/tb_sram_banked_2p.sv
// tb_sram_banked_2p: directed + randomized bench with a word-level memory
// model (associative array) for sram_banked_2p at NUM_WORDS=6144.
module tb_sram_banked_2p;
  localparam int NW = 6144;
  localparam int AW = 13;
  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  sram_banked_2p_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
  sram_banked_2p_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();

  sram_banked_2p #(.NUM_WORDS(NW), .DATA_W(DW)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .p0        (p0_if),
    .p1        (p1_if),
    .stall_cnt (stall_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // request registers (what the bench drives this cycle)
  bit          rv [2];
  bit          rw [2];
  logic [12:0] ra [2];
  logic [63:0] rdd[2];
  bit          acc[2];

  // reference model state
  logic [63:0] mem [int];
  bit          erv[2];
  logic [63:0] erd[2];
  bit          ek [2];
  int          estall;
  bit          eptr;

  task automatic step(input bit r);
    int  bk[2];
    bit  oo[2];
    bit  cf, w, er[2];
    @(negedge clk);
    chk("p0_rvalid", 64'(p0_if.rvalid), 64'(erv[0]));
    chk("p1_rvalid", 64'(p1_if.rvalid), 64'(erv[1]));
    if (ek[0]) chk("p0_rdata", p0_if.rdata, erd[0]);
    if (ek[1]) chk("p1_rdata", p1_if.rdata, erd[1]);
    chk("stall_cnt", 64'(stall_cnt), 64'(estall));
    rst = r;
    p0_if.valid = rv[0]; p0_if.we = rw[0]; p0_if.addr = ra[0]; p0_if.wdata = rdd[0];
    p1_if.valid = rv[1]; p1_if.we = rw[1]; p1_if.addr = ra[1]; p1_if.wdata = rdd[1];
    #1;
    for (int p = 0; p < 2; p++) begin
      bk[p] = int'(ra[p]) / 2048;
      oo[p] = bk[p] >= 3;
    end
    cf = rv[0] && rv[1] && !oo[0] && !oo[1] && bk[0] == bk[1];
`ifdef SRAM_RR_ARB_EN
    w = eptr;
`else
    w = 1'b0;
`endif
    er[0] = !r && !(cf && w);
    er[1] = !r && !(cf && !w);
    if (r || rv[0]) chk("p0_ready", 64'(p0_if.ready), 64'(er[0]));
    if (r || rv[1]) chk("p1_ready", 64'(p1_if.ready), 64'(er[1]));
    for (int p = 0; p < 2; p++) acc[p] = rv[p] && er[p];
    if (r) begin
      for (int p = 0; p < 2; p++) begin erv[p] = 0; erd[p] = '0; ek[p] = 1; end
      estall = 0;
      eptr   = 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        erv[p] = acc[p] && !rw[p];
        if (erv[p]) begin
          if (oo[p])                  begin erd[p] = '0;            ek[p] = 1; end
          else if (mem.exists(ra[p])) begin erd[p] = mem[int'(ra[p])]; ek[p] = 1; end
          else                         ek[p] = 0;
        end
      end
      for (int p = 0; p < 2; p++)
        if (acc[p] && rw[p] && !oo[p]) mem[int'(ra[p])] = rdd[p];
      if (cf) begin
        if (estall < 65535) estall++;
        eptr = !w;
      end
    end
  endtask

  task automatic req(input int p, input bit v, input bit we, input int ad, input logic [63:0] d);
    rv[p] = v; rw[p] = we; ra[p] = 13'(ad); rdd[p] = d;
  endtask

  task automatic idle();
    req(0, 0, 0, 0, '0);
    req(1, 0, 0, 0, '0);
  endtask

  int pool[10] = '{'h000, 'h005, 'h010, 'h7FF, 'h800, 'h810, 'h1000, 'h17FF, 'h1800, 'h1FFF};

  initial begin
    p0_if.valid = 0; p0_if.we = 0; p0_if.addr = '0; p0_if.wdata = '0;
    p1_if.valid = 0; p1_if.we = 0; p1_if.addr = '0; p1_if.wdata = '0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    for (int p = 0; p < 2; p++) begin erv[p] = 0; erd[p] = '0; ek[p] = 1; end
    estall = 0; eptr = 0;

    // write then read back on the other port
    req(0, 1, 1, 'h005, 64'hDEAD_BEEF_0000_0001); step(0);
    idle(); req(1, 1, 0, 'h005, '0);              step(0);
    idle();                                        step(0);
    chk("wr_rd_p1", p1_if.rdata, 64'hDEAD_BEEF_0000_0001);

    // different banks in the same cycle
    req(0, 1, 1, 'h010, 64'h1111_2222_3333_4444); req(1, 0, 0, 0, '0); step(0);
    req(0, 1, 0, 'h010, '0); req(1, 1, 1, 'h810, 64'h5555_6666_7777_8888); step(0);
    idle(); step(0);
    chk("diffbank_stall", 64'(stall_cnt), 64'd0);
    chk("diffbank_rd", p0_if.rdata, 64'h1111_2222_3333_4444);

    // same-bank conflict held for 4 cycles
    req(0, 1, 0, 'h005, '0); req(1, 1, 0, 'h010, '0);
    repeat (4) step(0);
    idle(); step(0);
    chk("conflict_stall4", 64'(stall_cnt), 64'd4);

    // bank-crossing back-to-back reads
    req(0, 1, 1, 'h7FF, 64'hAAAA_0000_0000_07FF); req(1, 1, 1, 'h800, 64'hBBBB_0000_0000_0800); step(0);
    idle(); req(0, 1, 0, 'h7FF, '0); step(0);
    req(0, 1, 0, 'h800, '0); step(0);
    chk("xbank_rd0", p0_if.rdata, 64'hAAAA_0000_0000_07FF);
    idle(); step(0);
    chk("xbank_rd1", p0_if.rdata, 64'hBBBB_0000_0000_0800);

    // out-of-range write dropped, read returns zero
    req(0, 1, 1, 'h000, 64'hCAFE_F00D_1234_5678); step(0);
    req(0, 1, 1, 'h1800, 64'hFFFF_FFFF_FFFF_FFFF); step(0);
    req(0, 1, 0, 'h1800, '0); req(1, 1, 0, 'h000, '0); step(0);
    idle(); step(0);
    chk("oor_rd", p0_if.rdata, 64'd0);
    chk("oor_nohit", p1_if.rdata, 64'hCAFE_F00D_1234_5678);

    // read accepted right before reset
    req(0, 1, 0, 'h005, '0); step(0);
    step(1);
    idle(); step(0);
    chk("rst_rvalid", 64'(p0_if.rvalid), 64'd0);
    chk("rst_rdata", p0_if.rdata, 64'd0);

    // randomized traffic; a refused request is held until accepted
    for (int it = 0; it < 1500; it++) begin
      for (int p = 0; p < 2; p++)
        if (!rv[p] || acc[p])
          req(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              pool[$urandom_range(0, 9)], {$urandom, $urandom});
      step($urandom_range(0, 99) == 0);
    end
    idle(); step(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_banked_2p.md
Name: sram_banked_2p

Overview:
- Two-port, banked SRAM controller built from sram_32b_w2048 macros (single-port, CEN/WEN active-low, 1-cycle read latency).
- Generalises the single-port wrapper:
  - two independent valid/ready request ports;
  - per-bank arbitration, so both ports proceed in the same cycle when they hit different banks;
  - registered read-bank tracking and an rvalid per port;
  - a saturating conflict-stall counter.
- Sits between the PE array / OFIFO write path and the readout / L0 load path.

Parameters:
NUM_WORDS, 4096, total words; must be ≤2048 or a multiple of 2048
DATA_W, 64, word width in bits; multiple of 32
ADDR_W, $clog2(NUM_WORDS), address width (derived, do not override)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset
p0_valid  in  1  port-0 request valid
p0_ready  out  1  port-0 request accepted this cycle when valid&ready
p0_we  in  1  1=write, 0=read
p0_addr  in  ADDR_W  word address
p0_wdata  in  DATA_W  write data
p0_rvalid  out  1  read data valid
p0_rdata  out  DATA_W  read data
p1_valid, p1_ready, p1_we, p1_addr, p1_wdata, p1_rvalid, p1_rdata: same as port 0
stall_cnt  out  16  saturating count of cycles in which a valid request was refused due to a bank conflict

Behaviour:
- Banking
  - DEPTH_BLOCKS = ceil(NUM_WORDS/2048); SLICES = DATA_W/32.
  - Bank = addr[ADDR_W-1:11] if DEPTH_BLOCKS>1, else 0.
  - Macro address = addr[10:0], zero-extended when ADDR_W<11.
- Readiness
  - pX_ready is combinational; it may depend on both valids and addresses.
  - pX_ready = 0 whenever RESET=1.
  - Different banks, or only one port valid: each valid port is ready.
  - Same bank, both valid: the winner is ready, the loser is not; the loser must hold its request.
- Macro drive
  - An accepted request drives CEN=0 on its bank only, with WEN=~we.
  - Unselected banks have CEN=1.
- Writes: take effect at the accepting edge; no response.
- Reads
  - pX_rvalid=1 exactly one cycle after acceptance.
  - pX_rdata = Q of the bank registered at acceptance, never the current address's bank.
  - pX_rdata holds its last value while rvalid=0.
- Out-of-range addresses (bank ≥ DEPTH_BLOCKS)
  - Accepted, never conflict, no macro is enabled.
  - A write is dropped; a read returns rvalid=1 with rdata=0.
- Arbitration: default is fixed priority, port 0 wins.
- stall_cnt
  - Increments by 1 for each cycle with a conflict refusal.
  - Saturates at 16'hFFFF.
- Reset: values at the first cycle after RESET is sampled:
  - rvalid=0 on both ports; rdata=0 on both ports;
  - stall_cnt=0; RR pointer=0;
  - SRAM contents unaffected.
- Reset mid-operation
  - A read accepted in cycle t still gives rvalid in t+1, even if RESET=1 in t+1.
  - RESET=1 in cycle t forces ready=0 in t, so no acceptance occurs in t.

Optional Feature:
- Macro: SRAM_RR_ARB_EN.
- Defined: round-robin arbitration on a same-bank conflict.
  - A 1-bit pointer names the preferred port.
  - After each conflict grant, the pointer moves to the loser.
  - The pointer is unchanged on non-conflict cycles.
- Undefined: port 0 always wins and the pointer logic is absent.

Decomposition:
- Shared package sram_pkg:
  - MACRO_WORDS=2048, MACRO_W=32, MACRO_AW=11;
  - typedef port_id_t (1 bit).
- One sub-module sram_bank_slice:
  - one depth bank made of SLICES macros in parallel;
  - ports CLK, CEN, WEN, A[10:0], D[DATA_W], Q[DATA_W].
- The top module holds arbitration, bank decode, read-bank registers and stall_cnt.

Test Plan:
- p0 writes 64'hDEAD_BEEF_0000_0001 @0x005; then p1 reads 0x005 → p1_rvalid=1 the next cycle, p1_rdata=64'hDEAD_BEEF_0000_0001.
- p0 reads @0x010 and p1 writes @0x810 in the same cycle (different banks) → both ready=1, stall_cnt stays 0, p0_rvalid the next cycle.
- Both ports hold valid on bank 0 for 4 cycles:
  - fixed priority: p1_ready=0 for all 4 cycles, stall_cnt=4;
  - with SRAM_RR_ARB_EN: grants alternate p0,p1,p0,p1, stall_cnt=4.
- p0 reads 0x7FF then 0x800 back-to-back → rdata tracks the registered bank each cycle (bank 0 data, then bank 1 data).
- NUM_WORDS=6144: write to 0x1800 is dropped; read of 0x1800 → rvalid=1, rdata=0; no macro CEN asserted.
- Read accepted at t, RESET=1 in t+1 → rvalid=1 in t+1; in t+2 rvalid=0, rdata=0, stall_cnt=0; ready=0 throughout t+1.
